// File: rtl/fixed_bias_add_pkg.sv
// Shared definitions for the fixed-point bias-add stage: derived shift/width
// helpers, parameter legality check and the per-lane round/saturate function.
package fixed_bias_add_pkg;

    // Width of the internal arithmetic field used by sat_round.
    localparam int CALC_W = 128;

    localparam logic signed [CALC_W-1:0] CALC_ONE = {{(CALC_W-1){1'b0}}, 1'b1};

    // Left shift that aligns the bias binary point to the accumulator's.
    function automatic int calc_sb(input int din_frac, input int bias_frac);
        return din_frac - bias_frac;
    endfunction

    // Right shift that moves the sum to the output binary point.
    function automatic int calc_so(input int din_frac, input int dout_frac);
        return din_frac - dout_frac;
    endfunction

    // Sum width: one guard bit above the wider aligned operand, so the add cannot overflow.
    function automatic int calc_sw(input int din_w, input int bias_w, input int sb);
        return ((din_w > (bias_w + sb)) ? din_w : (bias_w + sb)) + 1;
    endfunction

    // True when the parameter set describes a buildable stage.
    function automatic bit params_ok(input int sb, input int so, input int tensor, input int par);
        return (sb >= 0) && (so >= 0) && (par > 0) && ((tensor % par) == 0);
    endfunction

    // Round half-up at bit so, arithmetic shift right by so, then clamp to a
    // signed ow-bit range. The caller keeps the low ow bits of the result.
    function automatic logic [CALC_W-1:0] sat_round(input logic signed [CALC_W-1:0] v,
                                                    input int so, input int ow);
        logic signed [CALC_W-1:0] r;
        logic signed [CALC_W-1:0] mx;
        logic signed [CALC_W-1:0] mn;
        if (so > 0) begin
            r = v + (CALC_ONE <<< (so - 1));
        end else begin
            r = v;
        end
        r  = r >>> so;
        mx = (CALC_ONE <<< (ow - 1)) - CALC_ONE;
        mn = -(CALC_ONE <<< (ow - 1));
        if (r > mx) begin
            return mx;
        end else if (r < mn) begin
            return mn;
        end else begin
            return r;
        end
    endfunction

endpackage

// File: rtl/fixed_bias_add_skid_buffer.sv
// Two-entry output buffer (main + skid). Accept depends only on the skid
// register, so downstream ready never reaches the upstream readies.
module skid_buffer
#(
    parameter int W = 17
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_accept,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic [W-1:0] r_main;
    logic         r_main_valid;
    logic [W-1:0] r_skid;
    logic         r_skid_full;

    assign o_accept = ~r_skid_full;
    assign o_data   = r_main;
    assign o_valid  = r_main_valid;

    // Main/skid register update: drain skid first, otherwise load main, otherwise park in skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main       <= {W{1'b0}};
            r_main_valid <= 1'b0;
            r_skid       <= {W{1'b0}};
            r_skid_full  <= 1'b0;
        end else if (r_skid_full) begin
            if (i_ready) begin
                r_main      <= r_skid;
                r_skid_full <= 1'b0;
            end else begin
                r_main      <= r_main;
                r_skid_full <= 1'b1;
            end
        end else if (!r_main_valid || i_ready) begin
            r_main_valid <= i_valid;
            if (i_valid) begin
                r_main <= i_data;
            end else begin
                r_main <= r_main;
            end
        end else if (i_valid) begin
            r_skid      <= i_data;
            r_skid_full <= 1'b1;
        end else begin
            r_skid      <= r_skid;
            r_skid_full <= 1'b0;
        end
    end

endmodule

// File: rtl/fixed_bias_add.sv
// Streaming bias-add: joins accumulator and bias beats, aligns binary points,
// adds, rounds half-up, saturates and emits through a two-entry buffer with a
// row-end marker.
module fixed_bias_add
    import fixed_bias_add_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0  = 32,
    parameter int DATA_IN_0_PRECISION_1  = 8,
    parameter int BIAS_PRECISION_0       = 16,
    parameter int BIAS_PRECISION_1       = 3,
    parameter int DATA_OUT_0_PRECISION_0 = 16,
    parameter int DATA_OUT_0_PRECISION_1 = 4,
    parameter int PARALLELISM            = 1,
    parameter int TENSOR_SIZE_DIM_0      = 32
)
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [PARALLELISM],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    input  logic [BIAS_PRECISION_0-1:0]       bias [PARALLELISM],
    input  logic                              bias_valid,
    output logic                              bias_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [PARALLELISM],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    output logic                              data_out_0_last
);

    localparam int SB       = calc_sb(DATA_IN_0_PRECISION_1, BIAS_PRECISION_1);
    localparam int SO       = calc_so(DATA_IN_0_PRECISION_1, DATA_OUT_0_PRECISION_1);
    localparam int SW       = calc_sw(DATA_IN_0_PRECISION_0, BIAS_PRECISION_0, SB);
    localparam int COLS     = TENSOR_SIZE_DIM_0 / PARALLELISM;
    localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int OUT_BITS = PARALLELISM * DATA_OUT_0_PRECISION_0 + 1;
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    if (!params_ok(SB, SO, TENSOR_SIZE_DIM_0, PARALLELISM)) begin : g_bad_params
        $error("fixed_bias_add: fractional bits or row length inconsistent with lane count");
    end

    logic                w_accept;
    logic                w_xfer;
    logic                w_last;
    logic [OUT_BITS-1:0] w_pack;
    logic [OUT_BITS-1:0] w_out;
    logic [CW-1:0]       r_col;

    // Both streams are consumed together, and only when the buffer can take a beat.
    assign data_in_0_ready = bias_valid & w_accept;
    assign bias_ready      = data_in_0_valid & w_accept;
    assign w_xfer          = data_in_0_valid & bias_valid & w_accept;
    assign w_last          = (r_col == COL_MAX);

    for (genvar l = 0; l < PARALLELISM; l++) begin : g_lane
        logic signed [SW:0] w_data_ext;
        logic signed [SW:0] w_bias_ext;
        logic signed [SW:0] w_sum;

        assign w_data_ext = {{(SW + 1 - DATA_IN_0_PRECISION_0){data_in_0[l][DATA_IN_0_PRECISION_0-1]}},
                             data_in_0[l]};
        assign w_bias_ext = {{(SW + 1 - BIAS_PRECISION_0){bias[l][BIAS_PRECISION_0-1]}},
                             bias[l]} <<< SB;
        assign w_sum      = w_data_ext + w_bias_ext;
        assign w_pack[l*DATA_OUT_0_PRECISION_0 +: DATA_OUT_0_PRECISION_0] =
            DATA_OUT_0_PRECISION_0'(sat_round({{(CALC_W - 1 - SW){w_sum[SW]}}, w_sum},
                                              SO, DATA_OUT_0_PRECISION_0));
        assign data_out_0[l] = w_out[l*DATA_OUT_0_PRECISION_0 +: DATA_OUT_0_PRECISION_0];
    end

    assign w_pack[OUT_BITS-1] = w_last;
    assign data_out_0_last    = w_out[OUT_BITS-1];

    // Column counter: advances once per joined transfer and wraps at the row end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= {CW{1'b0}};
        end else if (w_xfer) begin
            if (r_col == COL_MAX) begin
                r_col <= {CW{1'b0}};
            end else begin
                r_col <= r_col + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            r_col <= r_col;
        end
    end

    skid_buffer #(
        .W (OUT_BITS)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_data   (w_pack),
        .i_valid  (w_xfer),
        .o_accept (w_accept),
        .o_data   (w_out),
        .o_valid  (data_out_0_valid),
        .i_ready  (data_out_0_ready)
    );

endmodule
